// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_loadext;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_loadext, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_loadext, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait latency, big-endian
// byte/half/word access with load sign/zero extension.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic            lat_write;
  logic            lat_loadext;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [1:0]      lat_size;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            accept;
  logic            do_access;
  logic            acc_err;
  logic [AW-1:0]   word_idx;
  logic [31:0]     cur_word;
  logic [31:0]     new_word;
  logic [31:0]     load_data;
  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  // Big-endian lanes: offset 0 is the most significant lane, so shift = (3 - offset) * 8
  assign word_idx = lat_addr[AW+1:2];
  assign cur_word = mem[word_idx];
  assign byte_sh  = {~lat_addr[1:0], 3'b000};
  assign half_sh  = {~lat_addr[1], 4'b0000};
  assign lane_b   = 8'(cur_word >> byte_sh);
  assign lane_h   = 16'(cur_word >> half_sh);

  assign bus.resp_valid = rsp_valid;
  assign bus.resp_rdata = rsp_rdata;
  assign bus.resp_err   = rsp_err;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.req_valid ? BUSY : IDLE;
      BUSY:    state_next = (cnt == 4'd0) ? RESP : BUSY;
      RESP:    state_next = bus.resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and strobes
  always_comb begin
    bus.req_ready = (state == IDLE);
    accept        = (state == IDLE) && bus.req_valid;
    do_access     = (state == BUSY) && (cnt == 4'd0);
  end

  // Lane extraction, load extension, store merge and error detection
  always_comb begin
    acc_err   = 1'b0;
    load_data = 32'd0;
    new_word  = cur_word;
    case (lat_size)
      2'b00: begin
        load_data = lat_loadext ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
        new_word  = (cur_word & ~(32'h0000_00FF << byte_sh)) | ({24'd0, lat_wdata[7:0]} << byte_sh);
      end
      2'b01: begin
        acc_err   = lat_addr[0];
        load_data = lat_loadext ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
        new_word  = (cur_word & ~(32'h0000_FFFF << half_sh)) | ({16'd0, lat_wdata[15:0]} << half_sh);
      end
      2'b10: begin
        acc_err   = (lat_addr[1:0] != 2'b00);
        load_data = cur_word;
        new_word  = lat_wdata;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Array write; a store aborted by reset in BUSY never commits
  always_ff @(posedge clock) begin
    if (do_access && lat_write && !acc_err && !reset) begin
      mem[word_idx] <= new_word;
    end
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= 4'd0;
      lat_write   <= 1'b0;
      lat_loadext <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= 32'd0;
      lat_size    <= 2'b00;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        cnt         <= 4'(LATENCY);
        lat_write   <= bus.req_write;
        lat_loadext <= bus.req_loadext;
        lat_addr    <= bus.req_addr[AW+1:0];
        lat_wdata   <= bus.req_wdata;
        lat_size    <= bus.req_size;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (lat_write || acc_err) ? 32'd0 : load_data;
        rsp_err   <= acc_err;
      end else if (state == RESP && bus.resp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: byte-addressed reference memory, directed cases with
// literal expectations, then randomized requests.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mem_m [int];
  logic        in_resp  = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;
  logic        exp_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: bytes at ascending addresses, most significant byte first
  function automatic void model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [1:0] size, input logic ext,
                                       output logic [31:0] rdata, output logic err, output logic known);
    int nb;
    int base;
    logic [31:0] v;
    base  = int'(addr & 32'(4 * DEPTH - 1));
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    rdata = 32'd0;
    known = 1'b1;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_m[base + i] = 8'(wdata >> (8 * (nb - 1 - i)));
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) begin
        if (!mem_m.exists(base + i)) known = 1'b0;
        else v = (v << 8) | 32'(mem_m[base + i]);
      end
      if (ext && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      rdata = v;
    end
  endfunction

  // Response-phase comparison on every cycle a response is presented
  always @(negedge clock) begin
    if (in_resp) begin
      check("resp_valid_held", 32'(bus.resp_valid), 32'd1);
      check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      check("resp_err", 32'(bus.resp_err), 32'(exp_err));
      if (exp_known) check("resp_rdata", bus.resp_rdata, exp_rdata);
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic ext, input int hold,
                        input logic use_lit, input logic [31:0] lit, input logic lit_err);
    int n;
    logic [31:0] r;
    logic e;
    logic k;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_loadext = ext;
    @(posedge clock);
    model_access(wr, addr, wdata, size, ext, r, e, k);
    if (use_lit) begin
      check("model_pin_rdata", r, lit);
      check("model_pin_err", 32'(e), 32'(lit_err));
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_size = 2'($urandom);
    bus.req_write = 1'($urandom); bus.req_loadext = 1'($urandom);
    n = 1;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("latency", 32'(n), 32'(LAT + 2));
    exp_rdata = r; exp_err = e; exp_known = k;
    in_resp = 1'b1;
    if (use_lit) begin
      check("lit_rdata", bus.resp_rdata, lit);
      check("lit_err", 32'(bus.resp_err), 32'(lit_err));
    end
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'($urandom);
      @(negedge clock);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clock);
    in_resp = 1'b0;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    check("idle_after_handshake", 32'({bus.req_ready, bus.resp_valid}), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.req_size = 2'd0; bus.req_loadext = 1'b0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    reset = 1'b0;

    do_req(1'b1, 32'h20, 32'h80FF7F01, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h80FF7F01, 1'b0);
    do_req(1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    do_req(1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 0, 1'b1, 32'h000000FF, 1'b0);
    do_req(1'b0, 32'h22, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'h0000007F, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 2'd1, 1'b1, 0, 1'b1, 32'hFFFF80FF, 1'b0);
    do_req(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, 1'b1, 32'h00007F01, 1'b0);
    do_req(1'b1, 32'h22, 32'hAB, 2'd0, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h80FFAB01, 1'b0);
    do_req(1'b1, 32'h20, 32'h1234, 2'd1, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h1234AB01, 1'b0);
    do_req(1'b0, 32'h22, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 32'h21, 32'h5555, 2'd1, 1'b0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 32'h20, 32'h0, 2'd3, 1'b0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 5, 1'b1, 32'h1234AB01, 1'b0);

    // Store aborted by reset in its first BUSY cycle must not commit
    do_req(1'b1, 32'h40, 32'h11223344, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h40;
    bus.req_wdata = 32'hDEADBEEF; bus.req_size = 2'd2;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_resp_rdata", bus.resp_rdata, 32'd0);
    reset = 1'b0;
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h11223344, 1'b0);

    // Reset coinciding with req_valid: nothing accepted
    reset = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h40; bus.req_size = 2'd2;
    @(negedge clock);
    reset = 1'b0; bus.req_valid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clock);
      check("rst_req_no_accept", 32'({bus.req_ready, bus.resp_valid}), 32'd2);
    end

    do_req(1'b1, 32'(4 * DEPTH + 8), 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 32'h9, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'hFFFFFFFE, 1'b0);

    for (int w = 0; w < 32; w++) do_req(1'b1, 32'(4 * w), $urandom, 2'd2, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    for (int t = 0; t < 160; t++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
      do_req(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'b0, 32'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
